// File: rtl/reflex_game_ctrl.sv
// Reflex-reaction game sequencer: countdown timer, LFSR target picker,
// hit/miss scoring and the IDLE/PLAY/RELEASE/DONE game state machine.
module reflex_game_ctrl #(
   parameter int unsigned TICK_DIV  = 100000000,
   parameter int unsigned GAME_SECS = 30,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] sw,
   output logic [5:0]  timer,
   output logic [5:0]  score,
   output logic [5:0]  misses,
   output logic [15:0] target,
   output logic        playing,
   output logic        game_over
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PLAY    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [5:0]    SECS_INIT = 6'(GAME_SECS);

   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      return (v == 6'd63) ? v : v + 6'd1;
   endfunction

   logic [1:0]    state_r, state_s, fsm_state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [15:0]   lfsr_r, sw_q_r, sw_rise_s, target_s, fsm_target_s;
   logic [3:0]    idx_r, idx_s, new_idx_s;
   logic [5:0]    timer_s, score_s, misses_s;
   logic          start_q_r, start_rise_s, lfsr_fb_s, in_game_s, tick_s, done_s;

   assign start_rise_s = start & ~start_q_r;
   assign sw_rise_s    = sw & ~sw_q_r;
   assign lfsr_fb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
   // Bump a repeated index so consecutive targets always differ.
   assign new_idx_s    = (lfsr_r[3:0] == idx_r) ? idx_r + 4'd1 : lfsr_r[3:0];
   assign in_game_s    = (state_r == PLAY) || (state_r == RELEASE);
   assign tick_s       = in_game_s && (cnt_r == CNT_MAX);
   assign done_s       = tick_s && (timer <= 6'd1);

   // Next-state, counter and scoreboard computation.
   always_comb begin
      fsm_state_s  = state_r;
      fsm_target_s = target;
      score_s      = score;
      misses_s     = misses;
      idx_s        = idx_r;
      if (in_game_s) begin
         cnt_s = tick_s ? CNT_ZERO : cnt_r + CNT_ONE;
      end else begin
         cnt_s = cnt_r;
      end
      if (tick_s) begin
         timer_s = done_s ? 6'd0 : timer - 6'd1;
      end else begin
         timer_s = timer;
      end
      case (state_r)
         IDLE, DONE: begin
            if (start_rise_s) begin
               timer_s      = SECS_INIT;
               score_s      = 6'd0;
               misses_s     = 6'd0;
               cnt_s        = CNT_ZERO;
               idx_s        = new_idx_s;
               fsm_target_s = 16'd1 << new_idx_s;
               fsm_state_s  = PLAY;
            end else begin
               fsm_target_s = (state_r == DONE) ? 16'hFFFF : 16'h0000;
            end
         end
         PLAY: begin
            if (sw_rise_s != 16'h0000) begin
               if (sw_rise_s == target) begin
                  score_s = sat_inc(score);
               end else begin
                  misses_s = sat_inc(misses);
               end
               fsm_target_s = 16'h0000;
               fsm_state_s  = RELEASE;
            end else begin
               fsm_target_s = target;
            end
         end
         RELEASE: begin
            if (sw == 16'h0000) begin
               idx_s        = new_idx_s;
               fsm_target_s = 16'd1 << new_idx_s;
               fsm_state_s  = PLAY;
            end else begin
               fsm_target_s = 16'h0000;
            end
         end
         default: begin
            fsm_state_s  = IDLE;
            fsm_target_s = 16'h0000;
         end
      endcase
      // Reaching zero on a tick wins over any other transition.
      state_s  = done_s ? DONE : fsm_state_s;
      target_s = done_s ? 16'hFFFF : fsm_target_s;
   end

   // State, outputs, edge-detect history and LFSR registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         lfsr_r    <= LFSR_SEED;
         sw_q_r    <= 16'h0000;
         start_q_r <= 1'b0;
         idx_r     <= 4'd0;
         timer     <= 6'd0;
         score     <= 6'd0;
         misses    <= 6'd0;
         target    <= 16'h0000;
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         lfsr_r    <= {lfsr_r[14:0], lfsr_fb_s};
         sw_q_r    <= sw;
         start_q_r <= start;
         idx_r     <= idx_s;
         timer     <= timer_s;
         score     <= score_s;
         misses    <= misses_s;
         target    <= target_s;
         playing   <= (state_s == PLAY) || (state_s == RELEASE);
         game_over <= (state_s == DONE);
      end
   end

endmodule

// File: tb/tb_reflex_game_ctrl.sv
// Directed bench for reflex_game_ctrl: per-cycle vector table plus
// hand-written hit, final-tick, restart, saturation and reset sequences.
module tb_reflex_game_ctrl;

   localparam int unsigned TD = 4;
   localparam int unsigned GS = 63;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] sw;
   logic [5:0]  timer, score, misses;
   logic [15:0] target;
   logic        playing, game_over;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int p0     = 0;

   reflex_game_ctrl #(.TICK_DIV(TD), .GAME_SECS(GS), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .start(start), .sw(sw),
      .timer(timer), .score(score), .misses(misses), .target(target),
      .playing(playing), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // tmode: 0 = target zero, 1 = target one-hot, 2 = target all ones
   typedef struct {
      logic        start;
      logic [15:0] sw;
      logic [5:0]  timer;
      logic [5:0]  score;
      logic [5:0]  misses;
      logic        playing;
      logic        game_over;
      int          tmode;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_onehot(input string name);
      n_chk++;
      if ($countones(target) != 1) begin
         n_fail++;
         $display("FAIL %s: target %0h is not one-hot (cycle %0d)", name, target, cyc);
      end
   endtask

   task automatic chk_target(input string name, input int mode);
      if (mode == 1) chk_onehot(name);
      else if (mode == 2) chk(name, target, 32'h0000FFFF);
      else chk(name, target, 32'h0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_timer"}, timer, 32'd0);
      chk({tag, "_score"}, score, 32'd0);
      chk({tag, "_misses"}, misses, 32'd0);
      chk({tag, "_target"}, target, 32'd0);
      chk({tag, "_playing"}, playing, 32'd0);
      chk({tag, "_game_over"}, game_over, 32'd0);
   endtask

   initial begin
      logic [15:0] t;
      int          exp_score;

      vecs[0] = '{1'b0, 16'h0000, 6'd0,  6'd0, 6'd0, 1'b0, 1'b0, 0};
      vecs[1] = '{1'b1, 16'h0000, 6'd63, 6'd0, 6'd0, 1'b1, 1'b0, 1};
      vecs[2] = '{1'b1, 16'h0000, 6'd63, 6'd0, 6'd0, 1'b1, 1'b0, 1};
      vecs[3] = '{1'b0, 16'h0003, 6'd63, 6'd0, 6'd1, 1'b1, 1'b0, 0};
      vecs[4] = '{1'b0, 16'h0003, 6'd63, 6'd0, 6'd1, 1'b1, 1'b0, 0};
      vecs[5] = '{1'b1, 16'h0001, 6'd62, 6'd0, 6'd1, 1'b1, 1'b0, 0};
      vecs[6] = '{1'b0, 16'h0000, 6'd62, 6'd0, 6'd1, 1'b1, 1'b0, 1};
      vecs[7] = '{1'b0, 16'hFFFF, 6'd62, 6'd0, 6'd2, 1'b1, 1'b0, 0};
      vecs[8] = '{1'b0, 16'h0000, 6'd62, 6'd0, 6'd2, 1'b1, 1'b0, 1};
      vecs[9] = '{1'b0, 16'h0000, 6'd61, 6'd0, 6'd2, 1'b1, 1'b0, 1};

      rst = 1'b1; start = 1'b0; sw = 16'h0000;
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Idle: switch activity without start changes nothing.
      for (int i = 0; i < 3; i++) begin
         sw = 16'h0101 << i;
         step();
         chk_zero("idle");
      end
      sw = 16'h0000;
      step();

      for (int i = 0; i < 10; i++) begin
         start = vecs[i].start;
         sw    = vecs[i].sw;
         step();
         if (i == 1) p0 = cyc;
         chk($sformatf("vec%0d_timer", i), timer, vecs[i].timer);
         chk($sformatf("vec%0d_score", i), score, vecs[i].score);
         chk($sformatf("vec%0d_misses", i), misses, vecs[i].misses);
         chk($sformatf("vec%0d_playing", i), playing, vecs[i].playing);
         chk($sformatf("vec%0d_game_over", i), game_over, vecs[i].game_over);
         chk_target($sformatf("vec%0d_target", i), vecs[i].tmode);
      end

      // Hit on the shown target.
      t = target;
      sw = t;
      step();
      chk("hit_score", score, 32'd1);
      chk("hit_target", target, 32'd0);
      chk("hit_misses", misses, 32'd2);
      sw = 16'h0000;
      step();
      chk_onehot("hit_newtarget");
      n_chk++;
      if (target == t) begin
         n_fail++;
         $display("FAIL hit_differ: new target %0h equals previous %0h", target, t);
      end

      // Single wrong bit is a miss.
      t = target;
      sw = {t[14:0], t[15]};
      step();
      chk("wrong_misses", misses, 32'd3);
      chk("wrong_score", score, 32'd1);
      chk("wrong_target", target, 32'd0);
      sw = 16'h0000;
      step();
      chk_onehot("wrong_newtarget");

      // Start pulse during PLAY is ignored.
      start = 1'b1;
      step();
      chk("play_start_timer", timer, 32'(GS - (cyc - p0) / TD));
      chk("play_start_score", score, 32'd1);
      chk("play_start_playing", playing, 32'd1);
      start = 1'b0;

      while (cyc - p0 < 251) step();
      chk("pre_final_timer", timer, 32'd1);
      chk("pre_final_playing", playing, 32'd1);

      // Hit on the same edge as the final tick.
      t = target;
      sw = t;
      step();
      chk("final_score", score, 32'd2);
      chk("final_misses", misses, 32'd3);
      chk("final_timer", timer, 32'd0);
      chk("final_game_over", game_over, 32'd1);
      chk("final_playing", playing, 32'd0);
      chk("final_target", target, 32'h0000FFFF);

      sw = 16'h0000;
      step();
      sw = 16'h0F0F;
      step();
      chk("done_hold_score", score, 32'd2);
      chk("done_hold_game_over", game_over, 32'd1);
      chk("done_hold_target", target, 32'h0000FFFF);
      sw = 16'h0000;
      step();

      // Restart from DONE.
      start = 1'b1;
      step();
      p0 = cyc;
      chk("restart_score", score, 32'd0);
      chk("restart_misses", misses, 32'd0);
      chk("restart_timer", timer, 32'd63);
      chk("restart_playing", playing, 32'd1);
      chk("restart_game_over", game_over, 32'd0);
      chk_onehot("restart_target");
      start = 1'b0;

      // 64 hits: score must saturate at 63.
      exp_score = 0;
      for (int i = 0; i < 64; i++) begin
         t = target;
         sw = t;
         step();
         if (exp_score < 63) exp_score++;
         chk($sformatf("sat_score%0d", i), score, 32'(exp_score));
         sw = 16'h0000;
         step();
      end
      chk("sat_final_score", score, 32'd63);
      chk("sat_misses", misses, 32'd0);
      chk("sat_playing", playing, 32'd1);

      // Asynchronous reset mid-game.
      #2;
      rst = 1'b1;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_zero("post_reset");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
